instruction_encoder: RTL
========================

# instruction_encoder

Streaming MIPS32 instruction encoder, the inverse of the instruction decoder. It accepts requests of the form (op_flags_t, decoded_info_t) over a valid/ready handshake and packs each into a 32-bit instruction word. Each word is buffered and emitted with its sequential word address. It sits between the test-program generator or boot loader and the instruction-memory write port.

## Interface
Parameters:
- FIFO_DEPTH, 2: output buffer entries; power of two, ≥2.
- COUNT_W, 16: width of the `words_out` counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; loads base_addr and enters RUN. Honoured in IDLE only.
- base_addr  in  32  address of the first emitted word; bits [1:0] are ignored (forced 0).
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  op_flags_t  operation flags, one-hot.
- in_info  in  decoded_info_t  fields. Uses rs, rt, rd, funct, imm16 and jump_target; the extended-immediate fields are ignored.
- in_last  in  1  marks the final request of a program.
- out_valid  out  1  buffered word available.
- out_ready  in  1  sink accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  32  byte address of out_instr.
- done  out  1  one-cycle pulse when the program has fully drained.
- err  out  1  sticky illegal-request flag; cleared by start or reset.
- words_out  out  COUNT_W  number of words emitted since start; wraps.

## Operation
- States:
  - IDLE → RUN on start.
  - RUN → DRAIN on acceptance of an in_last request.
  - DRAIN → IDLE once the FIFO is empty and no output handshake is pending; done pulses in that cycle.
- in_ready = (state==RUN) && !fifo_full. It is 0 in IDLE and DRAIN.
- Encoding. shamt is always 0.
  - alu_r: {6'h00, rs, rt, rd, 5'h0, funct}.
  - jr: {6'h00, rs, 15'h0, 6'h08}.
  - syscall: 32'h0000000C.
  - ori 6'h0d, lw 6'h23, sw 6'h2b, beq 6'h04: {op, rs, rt, imm16}.
  - lui: {6'h0f, 5'h0, rt, imm16}.
  - j 6'h02, jal 6'h03: {op, jump_target}.
- Address: an internal next_addr loads base_addr on start. It increments by 4 on each FIFO write and wraps modulo 2^32. Address and word are stored together in the FIFO.
- Illegal request (see Configuration): the request is consumed, nothing is written, next_addr is unchanged and err is set. in_last on an illegal request still moves the FSM to DRAIN.
- words_out increments on each out_valid && out_ready and resets to 0 on start.
- start in RUN or DRAIN: ignored.
- start and in_valid in the same cycle while in IDLE: the request is not accepted.

## Timing
- Reset values: in_ready=0, out_valid=0, out_instr=0, out_addr=0, done=0, err=0, words_out=0, state=IDLE, FIFO empty.
- Latency: a request accepted in cycle N appears on out_valid in cycle N+1.
- Throughput: one word per cycle when out_ready is held at 1.
- A simultaneous FIFO push and pop when full is not possible, because in_ready already reflects full.
- out_instr and out_addr stay stable while out_valid && !out_ready.
- A reset in any state takes effect at the next edge: the FIFO is flushed and buffered words are lost.

## Configuration
- `INSTRUCTION_ENCODER_CHECK_EN` defined:
  - A request is illegal if in_op is not exactly one-hot.
  - A request is illegal if alu_r has funct ∉ {6'h21, 6'h23}.
- Undefined:
  - No checks are made and err is tied to 0.
  - Multiple flags are resolved by priority alu_r > ori > lui > lw > sw > beq > j > jal > jr > syscall.
  - All-zero flags encode 32'h00000000 (nop), which is written and consumes an address.

## Structure
- Shared package mips32_pkg holds op_flags_t, decoded_info_t, the opcode localparams (OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL) and the funct localparams (FN_ADDU, FN_SUBU, FN_JR, FN_SYSCALL). The decoder imports the same package.
- Sub-module: sync_fifo, parameterised by width (64) and depth, with full/empty outputs. It is clocked on clk with synchronous active-low reset rst_n.
- The encode mux is purely combinational inside instruction_encoder.

## Test plan
- Single ori: start with base_addr=0x00400000, then ori rs=0 rt=8 imm16=0x1234 → out_instr=0x34081234, out_addr=0x00400000, one cycle after acceptance.
- Back-to-back requests with out_ready=1:
  - addu rs=9 rt=10 rd=8 funct=0x21 → 0x012A4021 @0x00400000.
  - jal target=0x0100000 → 0x0C100000 @0x00400004.
  - words_out=2.
- Backpressure (FIFO_DEPTH=2, out_ready=0, 3 requests) → in_ready drops after 2 acceptances and the outputs hold stable. When out_ready is released, all 3 words emerge in order at consecutive addresses.
- Illegal request, ori and lw flags both set:
  - With CHECK_EN: err=1, no word emitted; the next legal request uses the same address.
  - Without CHECK_EN: the request encodes as ori.
- Wrap and last: base_addr=0xFFFFFFFC, lw then syscall with in_last → addresses 0xFFFFFFFC and 0x00000000, second word 0x0000000C. done pulses once after the final handshake, then the FSM is in IDLE with in_ready=0.
- Reset mid-RUN with 2 words buffered → at the next cycle out_valid=0, words_out=0, err=0 and state=IDLE.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 field, opcode and funct definitions used by the encoder and decoder.
// Also carries the encoder FSM state type so benches can compare the debug state port.
package mips32_pkg;

   typedef struct packed {
      logic alu_r;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic jal;
      logic jr;
      logic syscall;
   } op_flags_t;

   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm16;
      logic [25:0] jump_target;
      logic [31:0] imm_sext;
      logic [31:0] imm_zext;
   } decoded_info_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;

   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_SYSCALL = 6'h0c;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } enc_state_t;

   function automatic logic is_onehot10(input logic [9:0] v);
      return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth; pointers carry one wrap bit to tell full from empty.
// Writes while full and reads while empty are dropped.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_wr;
   logic             w_rd;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_wr      = i_wr_en && !o_full;
   assign w_rd      = i_rd_en && !o_empty;
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming MIPS32 encoder: packs (op_flags_t, decoded_info_t) requests into words tagged with addresses.
// Define INSTRUCTION_ENCODER_CHECK_EN to reject non-one-hot flags and unsupported alu_r functs via err.
module instruction_encoder
   import mips32_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [31:0]        base_addr,
   input  logic               in_valid,
   output logic               in_ready,
   input  op_flags_t          in_op,
   input  decoded_info_t      in_info,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_instr,
   output logic [31:0]        out_addr,
   output logic               done,
   output logic               err,
   output logic [COUNT_W-1:0] words_out,
   output logic [1:0]         o_dbg_state
);

   enc_state_t         r_state;
   enc_state_t         w_next_state;
   logic [31:0]        r_next_addr;
   logic [COUNT_W-1:0] r_words_out;
   logic [31:0]        w_instr;
   logic [63:0]        w_fifo_rd;
   logic               w_accept;
   logic               w_legal;
   logic               w_push;
   logic               w_pop;
   logic               w_start;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic               w_unused_info;

   assign w_unused_info = ^{in_info.shamt, in_info.imm_sext, in_info.imm_zext};

   assign in_ready  = (r_state == ST_RUN) && !w_fifo_full;
   assign w_accept  = in_valid && in_ready;
   assign w_start   = start && (r_state == ST_IDLE);
   assign w_push    = w_accept && w_legal;
   assign w_pop     = out_valid && out_ready;

   // Priority chain doubles as the one-hot mux when flags are checked.
   always_comb begin
      w_instr = 32'h0;
      if (in_op.alu_r)        w_instr = {OP_SPECIAL, in_info.rs, in_info.rt, in_info.rd, 5'h0, in_info.funct};
      else if (in_op.ori)     w_instr = {OP_ORI, in_info.rs, in_info.rt, in_info.imm16};
      else if (in_op.lui)     w_instr = {OP_LUI, 5'h0, in_info.rt, in_info.imm16};
      else if (in_op.lw)      w_instr = {OP_LW, in_info.rs, in_info.rt, in_info.imm16};
      else if (in_op.sw)      w_instr = {OP_SW, in_info.rs, in_info.rt, in_info.imm16};
      else if (in_op.beq)     w_instr = {OP_BEQ, in_info.rs, in_info.rt, in_info.imm16};
      else if (in_op.j)       w_instr = {OP_J, in_info.jump_target};
      else if (in_op.jal)     w_instr = {OP_JAL, in_info.jump_target};
      else if (in_op.jr)      w_instr = {OP_SPECIAL, in_info.rs, 15'h0, FN_JR};
      else if (in_op.syscall) w_instr = {26'h0, FN_SYSCALL};
   end

`ifdef INSTRUCTION_ENCODER_CHECK_EN
   logic r_err;

   assign w_legal = is_onehot10(in_op) &&
                    !(in_op.alu_r && (in_info.funct != FN_ADDU) && (in_info.funct != FN_SUBU));
   assign err     = r_err;

   always_ff @(posedge clk) begin
      if (!rst_n)                     r_err <= 1'b0;
      else if (w_start)               r_err <= 1'b0;
      else if (w_accept && !w_legal)  r_err <= 1'b1;
   end
`else
   assign w_legal = 1'b1;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // DRAIN ends only once the buffer is empty, so the final handshake has already happened.
   always_comb begin
      w_next_state = r_state;
      done         = 1'b0;
      case (r_state)
         ST_IDLE:  if (start) w_next_state = ST_RUN;
         ST_RUN:   if (w_accept && in_last) w_next_state = ST_DRAIN;
         ST_DRAIN: begin
            if (w_fifo_empty) begin
               done         = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)       r_next_addr <= 32'h0;
      else if (w_start) r_next_addr <= {base_addr[31:2], 2'b00};
      else if (w_push)  r_next_addr <= r_next_addr + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)       r_words_out <= '0;
      else if (w_start) r_words_out <= '0;
      else if (w_pop)   r_words_out <= r_words_out + 1'b1;
   end

   sync_fifo #(
      .WIDTH (64),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_push),
      .i_wr_data ({r_next_addr, w_instr}),
      .i_rd_en   (w_pop),
      .o_rd_data (w_fifo_rd),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   // Outputs read as zero while empty so stale entries never leak after a flush.
   assign out_valid   = !w_fifo_empty;
   assign out_instr   = w_fifo_empty ? 32'h0 : w_fifo_rd[31:0];
   assign out_addr    = w_fifo_empty ? 32'h0 : w_fifo_rd[63:32];
   assign words_out   = r_words_out;
   assign o_dbg_state = r_state;

endmodule
